// File: rtl/weight_stream_seq_pkg.sv
// rtl/weight_stream_seq_pkg.sv - shared types, defaults and helpers for the weight streamer
package weight_stream_seq_pkg;

  // Default kernel size (coefficient words) and coefficient width
  localparam int KERN_S_1    = 9;
  localparam int COEFF_WIDTH = 16;

  // Width of the replay (pass) counter
  localparam int PASS_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ws_state_e;

  // Address width that stays legal for a single-word ROM
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/weight_stream_seq_coeff_skid_buf.sv
// rtl/weight_stream_seq_coeff_skid_buf.sv - two-entry staging FIFO for returning ROM words
module coeff_skid_buf #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]            count_q, count_d;
  logic [1:0]            remain;

  // Shift on pop, then land a push in the first free slot; caller never overfills or underflows
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    remain  = pop ? (count_q - 2'd1) : count_q;
    if (pop) begin
      slot0_d = slot1_q;
    end
    if (push) begin
      if (remain == 2'd0) begin
        slot0_d = push_data;
      end else begin
        slot1_d = push_data;
      end
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = slot0_q;

endmodule

// File: rtl/weight_stream_seq.sv
// rtl/weight_stream_seq.sv - replays a coefficient ROM N_PASS times into a FIFO
module weight_stream_seq
  import weight_stream_seq_pkg::*;
#(
  parameter int  MEM_SIZE   = KERN_S_1,
  parameter int  DATA_WIDTH = COEFF_WIDTH,
  parameter int  N_PASS     = 1,
  localparam int AW         = addr_width(MEM_SIZE)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [AW-1:0]         weight_address,
  output logic                  weight_ce,
  input  logic [DATA_WIDTH-1:0] weight_q,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
);

  ws_state_e             state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] buf_head;
  logic                  xfer, issue, last_read, last_word, buf_push, buf_pop;
  logic                  last_addr, last_pass;
  logic [2:0]            pending, level;

  // A returning ROM word is presented straight to the FIFO when nothing older is buffered
  always_comb begin
    output_V_write = (buf_count != 2'd0) || inflight_q;
    if (buf_count != 2'd0) begin
      output_V_din = buf_head;
    end else if (inflight_q) begin
      output_V_din = weight_q;
    end else begin
      output_V_din = '0;
    end
  end

  // Read credit: issue only if the words already owed still fit in the two-entry buffer
  always_comb begin
    xfer      = output_V_write & output_V_full_n;
    pending   = {1'b0, buf_count} + {2'b0, inflight_q};
    level     = pending - {2'b0, xfer};
    issue     = (state_q == ST_RUN) && (level < 3'd2);
    last_addr = (addr_q == AW'(MEM_SIZE - 1));
    last_pass = (pass_q == PASS_W'(N_PASS - 1));
    last_read = issue && last_addr && last_pass;
    last_word = (state_q == ST_DRAIN) && xfer && (pending == 3'd1);
    buf_push  = inflight_q && !(xfer && (buf_count == 2'd0));
    buf_pop   = xfer && (buf_count != 2'd0);
  end

  // FSM state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start, stop issuing after the final read, finish on the final transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ap_start)  state_d = ST_RUN;
      ST_RUN:   if (last_read) state_d = ST_DRAIN;
      ST_DRAIN: if (last_word) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ap_idle        = (state_q == ST_IDLE);
    ap_done        = last_word;
    weight_ce      = issue;
    weight_address = addr_q;
  end

  // Address walk wraps per pass; counters return to zero after the last read
  always_comb begin
    addr_d     = addr_q;
    pass_d     = pass_q;
    inflight_d = issue;
    if (issue) begin
      if (last_addr) begin
        addr_d = '0;
        pass_d = last_pass ? '0 : (pass_q + PASS_W'(1));
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
  end

  // Datapath registers; reset drops any word still in flight
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      addr_q     <= '0;
      pass_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      inflight_q <= inflight_d;
    end
  end

  coeff_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .push     (buf_push),
    .push_data(weight_q),
    .pop      (buf_pop),
    .count    (buf_count),
    .head     (buf_head)
  );

endmodule

// File: tb/tb_weight_stream_seq.sv
// tb/tb_weight_stream_seq.sv - self-checking bench for weight_stream_seq
module tb_weight_stream_seq;

  logic clk = 1'b0;
  logic rst_n, ap_start, full_n;

  logic       idle_a, done_a, ce_a, w_a;
  logic [1:0] addr_a;
  logic [7:0] q_a, din_a;
  logic [7:0] rom_a [4];

  logic       idle_b, done_b, ce_b, w_b;
  logic [0:0] addr_b;
  logic [7:0] q_b, din_b;

  int checks = 0;
  int errors = 0;
  int cnum;
  int ce_h [64];
  int w_h [64];
  int din_h [64];
  int idle_h [64];
  int done_h [64];
  int ta_data[$], ta_cyc[$], ta_done[$];
  int tb_data[$], tb_cyc[$], tb_done[$];
  int exp_q[$];
  int done_cnt_a, done_cnt_b;

  always #5 clk = ~clk;

  weight_stream_seq #(.MEM_SIZE(4), .DATA_WIDTH(8), .N_PASS(2)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_idle(idle_a), .ap_done(done_a),
    .weight_address(addr_a), .weight_ce(ce_a), .weight_q(q_a),
    .output_V_din(din_a), .output_V_full_n(full_n), .output_V_write(w_a)
  );

  weight_stream_seq #(.MEM_SIZE(1), .DATA_WIDTH(8), .N_PASS(3)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_idle(idle_b), .ap_done(done_b),
    .weight_address(addr_b), .weight_ce(ce_b), .weight_q(q_b),
    .output_V_din(din_b), .output_V_full_n(full_n), .output_V_write(w_b)
  );

  // Synchronous ROMs with one cycle of read latency
  always @(posedge clk) if (ce_a) q_a <= rom_a[addr_a];
  always @(posedge clk) if (ce_b && addr_b == 1'b0) q_b <= 8'd7;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_logs();
    ta_data = {}; ta_cyc = {}; ta_done = {};
    tb_data = {}; tb_cyc = {}; tb_done = {};
    done_cnt_a = 0; done_cnt_b = 0;
    cnum = 0;
    for (int i = 0; i < 64; i++) begin
      ce_h[i] = 0; w_h[i] = 0; din_h[i] = 0; idle_h[i] = 0; done_h[i] = 0;
    end
  endtask

  // One cycle: apply inputs just after the edge, sample once everything has settled
  task automatic step(input logic st, input logic fn, input logic rn);
    @(posedge clk);
    #1;
    rst_n = rn; ap_start = st; full_n = fn;
    #3;
    if (cnum < 64) begin
      ce_h[cnum] = int'(ce_a); w_h[cnum] = int'(w_a); din_h[cnum] = int'(din_a);
      idle_h[cnum] = int'(idle_a); done_h[cnum] = int'(done_a);
    end
    if (w_a && full_n) begin
      ta_data.push_back(int'(din_a)); ta_cyc.push_back(cnum); ta_done.push_back(int'(done_a));
    end
    if (w_b && full_n) begin
      tb_data.push_back(int'(din_b)); tb_cyc.push_back(cnum); tb_done.push_back(int'(done_b));
    end
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    cnum++;
  endtask

  // Reference: the kernel in ROM order, replayed npass times
  task automatic build_exp_a(input int npass);
    exp_q = {};
    for (int p = 0; p < npass; p++)
      for (int i = 0; i < 4; i++) exp_q.push_back(int'(rom_a[i]));
  endtask

  task automatic check_seq_a(input string tag, input int n_done);
    int n;
    chk({tag, "_count"}, ta_data.size(), exp_q.size());
    n = (ta_data.size() < exp_q.size()) ? ta_data.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, ta_data[i], exp_q[i]);
      chk({tag, "_done_at_word"}, ta_done[i], ((i + 1) % 8 == 0) ? 1 : 0);
    end
    chk({tag, "_done_pulses"}, done_cnt_a, n_done);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_idle"}, int'(idle_a), 1);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_ce"}, int'(ce_a), 0);
    chk({tag, "_addr"}, int'(addr_a), 0);
    chk({tag, "_write"}, int'(w_a), 0);
    chk({tag, "_din"}, int'(din_a), 0);
  endtask

  initial begin
    int guard;
    int idle_cnt;
    rst_n = 1'b0; ap_start = 1'b0; full_n = 1'b1;
    rom_a[0] = 8'd10; rom_a[1] = 8'd11; rom_a[2] = 8'd12; rom_a[3] = 8'd13;
    clear_logs();

    repeat (3) @(posedge clk);
    #4;
    check_reset_outputs("reset");
    chk("reset_idle_b", int'(idle_b), 1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);

    // Free-flowing run
    clear_logs();
    build_exp_a(2);
    step(1'b1, 1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b1, 1'b1);
    chk("flow_ce_c1", ce_h[1], 1);
    chk("flow_write_c1", w_h[1], 0);
    chk("flow_write_c2", w_h[2], 1);
    chk("flow_din_c2", din_h[2], 10);
    for (int i = 0; i < ta_cyc.size() && i < 8; i++) chk("flow_xfer_cycle", ta_cyc[i], 2 + i);
    chk("flow_done_c9", done_h[9], 1);
    chk("flow_idle_c9", idle_h[9], 0);
    chk("flow_idle_c10", idle_h[10], 1);
    check_seq_a("flow", 1);

    // Backpressure cycles 3..6
    clear_logs();
    step(1'b1, 1'b1, 1'b1);
    for (int c = 1; c < 20; c++) step(1'b0, !(c >= 3 && c <= 6), 1'b1);
    for (int c = 3; c <= 6; c++) begin
      chk("bp_din_hold", din_h[c], 11);
      chk("bp_write_hold", w_h[c], 1);
    end
    chk("bp_ce_c5", ce_h[5], 0);
    chk("bp_ce_c6", ce_h[6], 0);
    check_seq_a("bp", 1);

    // Alternating full_n
    clear_logs();
    step(1'b1, 1'b1, 1'b1);
    for (int c = 1; c < 30; c++) step(1'b0, (c % 2) == 0, 1'b1);
    check_seq_a("toggle", 1);

    // Reset mid-run, then restart
    clear_logs();
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check_reset_outputs("midrst");
    step(1'b0, 1'b1, 1'b0);
    clear_logs();
    step(1'b1, 1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b1, 1'b1);
    chk("restart_first", (ta_data.size() > 0) ? ta_data[0] : -1, 10);
    chk("restart_first_cycle", (ta_cyc.size() > 0) ? ta_cyc[0] : -1, 2);
    check_seq_a("restart", 1);

    // ap_start held high: back-to-back runs
    clear_logs();
    build_exp_a(4);
    for (int c = 0; c < 20; c++) step(1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    check_seq_a("b2b", 2);
    idle_cnt = 0;
    for (int c = 1; c < 20; c++) idle_cnt += idle_h[c];
    chk("b2b_idle_gap", idle_cnt, 1);
    chk("b2b_idle_c10", idle_h[10], 1);

    // Random ROM contents and random backpressure
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 4; i++) rom_a[i] = 8'($urandom);
      build_exp_a(2);
      clear_logs();
      step(1'b1, 1'b1, 1'b1);
      guard = 0;
      while (done_cnt_a == 0 && guard < 200) begin
        step(1'b0, ($urandom % 4) != 0, 1'b1);
        guard++;
      end
      chk("rand_budget", (guard < 200) ? 1 : 0, 1);
      step(1'b0, 1'b1, 1'b1);
      chk("rand_idle_after", int'(idle_a), 1);
      check_seq_a("rand", 1);
    end

    // Single-word ROM, three passes
    clear_logs();
    step(1'b1, 1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1, 1'b1);
    chk("one_count", tb_data.size(), 3);
    for (int i = 0; i < tb_data.size() && i < 3; i++) begin
      chk("one_data", tb_data[i], 7);
      chk("one_cycle", tb_cyc[i], 2 + i);
      chk("one_done_at_word", tb_done[i], (i == 2) ? 1 : 0);
    end
    chk("one_done_pulses", done_cnt_b, 1);

    clear_logs();
    step(1'b1, 1'b1, 1'b1);
    guard = 0;
    while (done_cnt_b == 0 && guard < 100) begin
      step(1'b0, ($urandom % 2) != 0, 1'b1);
      guard++;
    end
    chk("one_rand_budget", (guard < 100) ? 1 : 0, 1);
    chk("one_rand_count", tb_data.size(), 3);
    for (int i = 0; i < tb_data.size() && i < 3; i++) chk("one_rand_data", tb_data[i], 7);
    chk("one_rand_last_done", (tb_done.size() == 3) ? tb_done[2] : -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
